multi_phase_signal_ctrl: RTL and testbench

Parametrised N-phase intersection signal controller, the next generation of our two-road main/side controller. It serves up to 8 conflicting phases with round-robin demand service, min/max green, yellow and all-red clearance intervals, and a flashing fail-safe mode. Timing runs on an external tick enable, so durations are independent of clk frequency. It sits between the vehicle-detector conditioning logic and the lamp-driver outputs.

---
 rtl/sig_ctrl_pkg.sv | 39 +++
 rtl/rr_phase_arbiter.sv | 48 ++++
 rtl/multi_phase_signal_ctrl.sv | 153 +++++++++++++++
 tb/tb_multi_phase_signal_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sig_ctrl_pkg.sv
// Shared definitions for the multi-phase signal controller: lamp codes,
// controller state encoding and the per-phase lamp decode.
package sig_ctrl_pkg;

   // Lamp codes as driven onto each 2-bit phase slot of the lights bus
   localparam logic [1:0] RED    = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] GREEN  = 2'b10;
   localparam logic [1:0] DARK   = 2'b11;

   // Phase indices are carried in 3 bits so up to 8 phases fit
   localparam int PHASE_W = 3;

   // Three-bit encoding leaves spare codes; those are treated as illegal
   typedef enum logic [2:0] {
      S_ALL_RED = 3'd0,
      S_GREEN   = 3'd1,
      S_YELLOW  = 3'd2,
      S_FLASH   = 3'd3
   } sig_state_t;

   // Lamp shown by one phase given the controller state.
   // is_cur: this phase is the served phase; is_zero: this is phase 0.
   function automatic logic [1:0] lamp_decode(input sig_state_t st,
                                              input logic       is_cur,
                                              input logic       is_zero,
                                              input logic       flash_on);
      logic [1:0] code;
      code = RED;
      case (st)
         S_GREEN:  code = is_cur ? GREEN : RED;
         S_YELLOW: code = is_cur ? YELLOW : RED;
         S_FLASH:  code = flash_on ? (is_zero ? YELLOW : RED) : DARK;
         default:  code = RED;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/rr_phase_arbiter.sv
// Combinational round-robin search for the next phase to serve.
// Scans cyclically from cur_phase+1; the current phase itself is the last
// candidate, and with no demand at all the current phase is returned.
module rr_phase_arbiter
   import sig_ctrl_pkg::*;
#(
   parameter int NUM_PHASES = 4
)
(
   input  logic [NUM_PHASES-1:0] demand_i,
   input  logic [PHASE_W-1:0]    cur_phase_i,
   output logic [PHASE_W-1:0]    nxt_idx_o,
   output logic                  any_other_o
);

   logic [7:0]            dem_ext;
   logic [PHASE_W-1:0]    cand_idx [NUM_PHASES];
   logic [NUM_PHASES-1:0] cand_hit;
   logic [NUM_PHASES-1:0] other_dem;

   assign dem_ext = 8'(demand_i);

   // Candidate gi is the phase (gi+1) steps after the current one, modulo N
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PHASES; gi++) begin : g_cand
         logic [3:0] sum;
         assign sum           = {1'b0, cur_phase_i} + 4'(gi + 1);
         assign cand_idx[gi]  = (sum >= 4'(NUM_PHASES)) ? 3'(sum - 4'(NUM_PHASES)) : sum[2:0];
         assign cand_hit[gi]  = dem_ext[cand_idx[gi]];
         assign other_dem[gi] = demand_i[gi] && (cur_phase_i != 3'(gi));
      end
   endgenerate

   // Nearest demanding candidate wins: scan from farthest to nearest so the
   // closest hit overwrites the rest
   always_comb begin
      nxt_idx_o = cur_phase_i;
      for (int i = NUM_PHASES - 1; i >= 0; i--) begin
         if (cand_hit[i]) begin
            nxt_idx_o = cand_idx[i];
         end
      end
   end

   assign any_other_o = |other_dem;

endmodule

// File: rtl/multi_phase_signal_ctrl.sv
// N-phase intersection signal controller: round-robin demand service with
// min/max green, yellow and all-red clearance, plus a flashing fail-safe.
// All intervals count tick enables, not clk cycles.
module multi_phase_signal_ctrl
   import sig_ctrl_pkg::*;
#(
   parameter int NUM_PHASES   = 4,
   parameter int TW           = 32,
   parameter int GREEN_MIN    = 30,
   parameter int GREEN_MAX    = 100,
   parameter int YELLOW_TIME  = 20,
   parameter int ALL_RED_TIME = 2,
   parameter int FLASH_PERIOD = 1
)
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    tick_i,
   input  logic [NUM_PHASES-1:0]   demand_i,
   input  logic                    flash_mode_i,
   output logic [2*NUM_PHASES-1:0] lights_o,
   output logic [2:0]              active_phase_o,
   output logic                    in_flash_o
);

   // Last timer value of each interval: a state lasting T ticks exits on the
   // tick where the timer reads T-1
   localparam logic [TW-1:0] GMIN_LAST  = TW'(GREEN_MIN - 1);
   localparam logic [TW-1:0] GMAX_LAST  = TW'(GREEN_MAX - 1);
   localparam logic [TW-1:0] YEL_LAST   = TW'(YELLOW_TIME - 1);
   localparam logic [TW-1:0] AR_LAST    = TW'(ALL_RED_TIME - 1);
   localparam logic [TW-1:0] FLASH_LAST = TW'(FLASH_PERIOD - 1);

   sig_state_t         state_q, state_d;
   logic [PHASE_W-1:0] cur_phase_q, cur_phase_d;
   logic [PHASE_W-1:0] nxt_phase_q, nxt_phase_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic               flash_on_q, flash_on_d;
   logic               flash_tgl;

   logic [7:0]         dem_ext;
   logic               dem_cur;
   logic [PHASE_W-1:0] arb_nxt;
   logic               arb_other;
   logic               el_gmin, el_gmax, el_yel, el_ar, el_flash;

   assign dem_ext = 8'(demand_i);
   assign dem_cur = dem_ext[cur_phase_q];

   assign el_gmin  = tick_i && (timer_q >= GMIN_LAST);
   assign el_gmax  = tick_i && (timer_q >= GMAX_LAST);
   assign el_yel   = tick_i && (timer_q >= YEL_LAST);
   assign el_ar    = tick_i && (timer_q >= AR_LAST);
   assign el_flash = tick_i && (timer_q >= FLASH_LAST);

   rr_phase_arbiter #(
      .NUM_PHASES (NUM_PHASES)
   ) u_arb (
      .demand_i    (demand_i),
      .cur_phase_i (cur_phase_q),
      .nxt_idx_o   (arb_nxt),
      .any_other_o (arb_other)
   );

   // Next-state logic: phase sequencing, next-phase latch and flash blink
   always_comb begin
      state_d     = state_q;
      cur_phase_d = cur_phase_q;
      nxt_phase_d = nxt_phase_q;
      flash_on_d  = flash_on_q;
      flash_tgl   = 1'b0;
      case (state_q)
         S_GREEN: begin
            if (el_gmin && (flash_mode_i || (arb_other && (!dem_cur || el_gmax)))) begin
               state_d     = S_YELLOW;
               nxt_phase_d = arb_nxt;
            end
         end
         S_YELLOW: begin
            if (el_yel) begin
               state_d = S_ALL_RED;
            end
         end
         S_ALL_RED: begin
            if (el_ar) begin
               if (flash_mode_i) begin
                  state_d = S_FLASH;
               end else begin
                  state_d     = S_GREEN;
                  cur_phase_d = nxt_phase_q;
               end
            end
         end
         S_FLASH: begin
            if (tick_i && !flash_mode_i) begin
               state_d     = S_ALL_RED;
               nxt_phase_d = '0;
               flash_on_d  = 1'b0;
            end else if (el_flash) begin
               flash_on_d = ~flash_on_q;
               flash_tgl  = 1'b1;
            end
         end
         default: begin
            state_d    = S_ALL_RED;
            flash_on_d = 1'b0;
         end
      endcase
   end

   // Interval timer: restarts on any state change or blink toggle, else
   // counts ticks and sticks at its maximum while green rests
   always_comb begin
      timer_d = timer_q;
      if ((state_d != state_q) || flash_tgl) begin
         timer_d = '0;
      end else if (tick_i && (timer_q != '1)) begin
         timer_d = timer_q + TW'(1);
      end
   end

   // Controller registers; reset forces all red immediately
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_ALL_RED;
         cur_phase_q <= '0;
         nxt_phase_q <= '0;
         timer_q     <= '0;
         flash_on_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_phase_q <= cur_phase_d;
         nxt_phase_q <= nxt_phase_d;
         timer_q     <= timer_d;
         flash_on_q  <= flash_on_d;
      end
   end

   // Lamp decode straight from registered state, one slot per phase
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PHASES; gi++) begin : g_lamp
         assign lights_o[2*gi+1 -: 2] = lamp_decode(state_q,
                                                    cur_phase_q == 3'(gi),
                                                    gi == 0,
                                                    flash_on_q);
      end
   endgenerate

   assign active_phase_o = cur_phase_q;
   assign in_flash_o     = (state_q == S_FLASH);

endmodule

// File: tb/tb_multi_phase_signal_ctrl.sv
// Scoreboard bench for multi_phase_signal_ctrl with short test timings.
// Expected {lights, active_phase, in_flash} words are queued as stimulus is
// applied and consumed one per cycle on the falling clock edge.
module tb_multi_phase_signal_ctrl;

   localparam int NP = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          tick;
   logic [NP-1:0] demand;
   logic          flash_mode;
   logic [2*NP-1:0] lights;
   logic [2:0]    active_phase;
   logic          in_flash;

   int n_vec = 0;
   int n_bad = 0;

   logic [11:0] exp_q [$];
   string       tag_q [$];

   always #5 clk = ~clk;

   multi_phase_signal_ctrl #(
      .NUM_PHASES   (NP),
      .TW           (32),
      .GREEN_MIN    (3),
      .GREEN_MAX    (8),
      .YELLOW_TIME  (2),
      .ALL_RED_TIME (1),
      .FLASH_PERIOD (2)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .tick_i         (tick),
      .demand_i       (demand),
      .flash_mode_i   (flash_mode),
      .lights_o       (lights),
      .active_phase_o (active_phase),
      .in_flash_o     (in_flash)
   );

   // Compare one observed output word against its expectation
   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got lights=%h act=%0d flash=%0b, want lights=%h act=%0d flash=%0b",
                  tag, obs[11:4], obs[3:1], obs[0], exp[11:4], exp[3:1], exp[0]);
      end else begin
         $display("ok   %s: lights=%h act=%0d flash=%0b", tag, obs[11:4], obs[3:1], obs[0]);
      end
   endtask

   // Queue n cycles of one expected output, then let those cycles elapse.
   // Called just after a rising edge; returns just after a rising edge.
   task automatic expect_for(input string tag, input logic [7:0] l, input logic [2:0] a,
                             input logic f, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({l, a, f});
         tag_q.push_back(tag);
      end
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer: one comparison per falling edge while work is queued
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         chk(tag_q.pop_front(), {lights, active_phase, in_flash}, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      tick       = 1'b1;
      demand     = '0;
      flash_mode = 1'b0;
      @(posedge clk);
      #1;

      // Reset state, then one all-red cycle and indefinite rest on phase 0
      expect_for("in_reset", 8'h00, 3'd0, 1'b0, 2);
      reset_n = 1'b1;
      expect_for("rst_allred", 8'h00, 3'd0, 1'b0, 1);
      expect_for("rest_p0", 8'h02, 3'd0, 1'b0, 50);

      // Demand on phase 2 after min green already served: leave immediately
      demand = 4'b0100;
      expect_for("p0_last_grn", 8'h02, 3'd0, 1'b0, 1);
      expect_for("p0_yellow", 8'h01, 3'd0, 1'b0, 2);
      expect_for("p0_allred", 8'h00, 3'd0, 1'b0, 1);
      expect_for("p2_green", 8'h20, 3'd2, 1'b0, 3);

      // Phase 3 latched, then demand drops: sequence still serves phase 3
      demand = 4'b1000;
      expect_for("p2_last_grn", 8'h20, 3'd2, 1'b0, 1);
      demand = 4'b0000;
      expect_for("p2_yel_drop", 8'h10, 3'd2, 1'b0, 2);
      expect_for("p2_ar_drop", 8'h00, 3'd2, 1'b0, 1);
      expect_for("p3_green", 8'h80, 3'd3, 1'b0, 1);

      // Wrap-around: from phase 3 with demand 0101 the next green is phase 0
      demand = 4'b0101;
      expect_for("p3_grn_min", 8'h80, 3'd3, 1'b0, 2);
      expect_for("p3_yellow", 8'h40, 3'd3, 1'b0, 2);
      expect_for("p3_allred", 8'h00, 3'd3, 1'b0, 1);
      // Own demand held plus conflicting demand: green ends at max green
      expect_for("p0_grn_max", 8'h02, 3'd0, 1'b0, 8);
      expect_for("p0_yel_max", 8'h01, 3'd0, 1'b0, 2);
      expect_for("p0_ar_max", 8'h00, 3'd0, 1'b0, 1);
      expect_for("p2_skip1", 8'h20, 3'd2, 1'b0, 1);

      // Flash request: clear through yellow/all-red, then dark/yellow blink
      demand     = 4'b0000;
      flash_mode = 1'b1;
      expect_for("fl_grn", 8'h20, 3'd2, 1'b0, 2);
      expect_for("fl_yel", 8'h10, 3'd2, 1'b0, 2);
      expect_for("fl_ar", 8'h00, 3'd2, 1'b0, 1);
      expect_for("flash_dark", 8'hFF, 3'd2, 1'b1, 2);
      expect_for("flash_on", 8'h01, 3'd2, 1'b1, 2);
      expect_for("flash_dark2", 8'hFF, 3'd2, 1'b1, 2);
      expect_for("flash_on2", 8'h01, 3'd2, 1'b1, 2);

      // Leave flash; fresh phase 0 green with demand on phase 2 from entry
      flash_mode = 1'b0;
      demand     = 4'b0100;
      expect_for("fl_exit", 8'hFF, 3'd2, 1'b1, 1);
      expect_for("fl_exit_ar", 8'h00, 3'd2, 1'b0, 1);
      expect_for("p0_grn_min", 8'h02, 3'd0, 1'b0, 3);
      expect_for("p0_yel_min", 8'h01, 3'd0, 1'b0, 2);
      expect_for("p0_ar_min", 8'h00, 3'd0, 1'b0, 1);
      expect_for("p2_entry", 8'h20, 3'd2, 1'b0, 1);

      // tick low freezes the timer: green holds despite conflicting demand
      tick   = 1'b0;
      demand = 4'b0001;
      expect_for("tick_frozen", 8'h20, 3'd2, 1'b0, 5);
      tick = 1'b1;
      expect_for("tick_resume", 8'h20, 3'd2, 1'b0, 2);
      expect_for("tick_yel", 8'h10, 3'd2, 1'b0, 2);
      expect_for("tick_ar", 8'h00, 3'd2, 1'b0, 1);
      expect_for("p0_back", 8'h02, 3'd0, 1'b0, 1);

      // Reset asserted in the middle of a yellow interval
      demand = 4'b0010;
      expect_for("r_grn", 8'h02, 3'd0, 1'b0, 2);
      expect_for("r_yel", 8'h01, 3'd0, 1'b0, 1);
      chk("pre_rst_yel", {lights, active_phase, in_flash}, {8'h01, 3'd0, 1'b0});
      reset_n = 1'b0;
      demand  = 4'b0000;
      #1;
      chk("async_rst", {lights, active_phase, in_flash}, {8'h00, 3'd0, 1'b0});
      @(posedge clk);
      #1;
      expect_for("rst_held", 8'h00, 3'd0, 1'b0, 2);
      reset_n = 1'b1;
      expect_for("rst2_allred", 8'h00, 3'd0, 1'b0, 1);
      expect_for("rst2_rest_p0", 8'h02, 3'd0, 1'b0, 6);

      chk("sb_drained", 12'(exp_q.size()), 12'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
